watch_mode_ctrl: RTL and testbench

WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

---
 rtl/watch_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/watch_mode_ctrl.sv | 125 ++++++++++++
 tb/tb_watch_mode_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared watch definitions: mode encodings, the front-panel strobe bundle and
// default timing, reused by the mode controller, alarm, timekeeper and stopwatch.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_TIME  = 2'd0,
    MODE_ALARM = 2'd1,
    MODE_SW    = 2'd2
  } mode_e;

  typedef struct packed {
    logic tk1;
    logic tk2;
    logic alm1;
    logic alm2;
    logic alm3;
    logic sw1;
    logic sw2;
  } strobe_t;

  localparam int DEB_CYCLES_DEFAULT = 50000;
  localparam int TIMEOUT_S_DEFAULT  = 30;
  localparam int IDLE_W             = 6;

  function automatic mode_e nextMode(input mode_e m);
    mode_e result;
    case (m)
      MODE_TIME:  result = MODE_ALARM;
      MODE_ALARM: result = MODE_SW;
      default:    result = MODE_TIME;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchronizer, stability debouncer and a
// single-cycle press pulse on the debounced rising edge.
module btn_debounce
  import watch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic In,
  output logic Level,
  output logic Press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // The count only survives while the synchronized input keeps disagreeing
  // with the accepted level; a single agreeing sample restarts it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= In;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign Level = r_level;
  assign Press = r_press;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch front-panel controller: debounces three buttons, sequences the
// TIME/ALARM/STOPWATCH mode and routes registered strobes to the active block.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int TIMEOUT_S  = TIMEOUT_S_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Button1,
  input  logic       Button2,
  input  logic       Button3,
  input  logic       Tick1Hz,
  input  logic       BuzzerBit,
  output logic [1:0] Mode,
  output logic       Button1Tk,
  output logic       Button2Tk,
  output logic       Button1Alm,
  output logic       Button2Alm,
  output logic       Button3Alm,
  output logic       Button1Sw,
  output logic       Button2Sw
);

  if (TIMEOUT_S < 1 || TIMEOUT_S > 63) begin : g_badTimeout
    $error("watch_mode_ctrl: TIMEOUT_S must be within 1..63");
  end

  logic [2:0] w_raw;
  logic [2:0] w_level;
  logic [2:0] w_press;
  logic       w_unusedLevels;

  assign w_raw = {Button3, Button2, Button1};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
      .Clk  (Clk),
      .Rst  (Rst),
      .In   (w_raw[g]),
      .Level(w_level[g]),
      .Press(w_press[g])
    );
  end

  assign w_unusedLevels = &w_level;

  mode_e             r_mode;
  logic [IDLE_W-1:0] r_idle;
  strobe_t           r_strobe;

  mode_e             w_nextMode;
  logic [IDLE_W-1:0] w_nextIdle;
  strobe_t           w_strobe;
  logic              w_accept;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mode   <= MODE_TIME;
      r_idle   <= '0;
      r_strobe <= '0;
    end else begin
      r_mode   <= w_nextMode;
      r_idle   <= w_nextIdle;
      r_strobe <= w_strobe;
    end
  end

  // Button3 outranks Button1 which outranks Button2; losers are dropped.
  // An accepted press always beats the ALARM idle timeout in the same cycle.
  always_comb begin
    w_nextMode = r_mode;
    w_nextIdle = r_idle;
    w_strobe   = '0;
    w_accept   = |w_press;

    if (w_press[2]) begin
      if (BuzzerBit) begin
        w_strobe.alm3 = 1'b1;
      end else begin
        w_nextMode = nextMode(r_mode);
      end
    end else if (w_press[0]) begin
      case (r_mode)
        MODE_TIME:  w_strobe.tk1  = 1'b1;
        MODE_ALARM: w_strobe.alm1 = 1'b1;
        MODE_SW:    w_strobe.sw1  = 1'b1;
        default:    w_strobe      = '0;
      endcase
    end else if (w_press[1]) begin
      case (r_mode)
        MODE_TIME:  w_strobe.tk2  = 1'b1;
        MODE_ALARM: w_strobe.alm2 = 1'b1;
        MODE_SW:    w_strobe.sw2  = 1'b1;
        default:    w_strobe      = '0;
      endcase
    end

    if (r_mode == MODE_ALARM) begin
      if (w_accept) begin
        w_nextIdle = '0;
      end else if (r_idle == IDLE_W'(TIMEOUT_S)) begin
        w_nextMode = MODE_TIME;
        w_nextIdle = '0;
      end else if (Tick1Hz) begin
        w_nextIdle = r_idle + IDLE_W'(1);
      end
    end else begin
      w_nextIdle = '0;
    end
  end

  assign Mode       = r_mode;
  assign Button1Tk  = r_strobe.tk1;
  assign Button2Tk  = r_strobe.tk2;
  assign Button1Alm = r_strobe.alm1;
  assign Button2Alm = r_strobe.alm2;
  assign Button3Alm = r_strobe.alm3;
  assign Button1Sw  = r_strobe.sw1;
  assign Button2Sw  = r_strobe.sw2;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: window-based behavioural model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_watch_mode_ctrl;

  localparam int DEB = 4;
  localparam int TO  = 3;
  localparam int S_TK1 = 6, S_TK2 = 5, S_ALM1 = 4, S_ALM2 = 3, S_ALM3 = 2, S_SW1 = 1, S_SW2 = 0;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Button1 = 1'b0, Button2 = 1'b0, Button3 = 1'b0;
  logic Tick1Hz = 1'b0, BuzzerBit = 1'b0;
  logic [1:0] Mode;
  logic Button1Tk, Button2Tk, Button1Alm, Button2Alm, Button3Alm, Button1Sw, Button2Sw;

  logic [6:0] dutStrobe;
  assign dutStrobe = {Button1Tk, Button2Tk, Button1Alm, Button2Alm, Button3Alm, Button1Sw, Button2Sw};

  watch_mode_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Button1(Button1), .Button2(Button2), .Button3(Button3),
    .Tick1Hz(Tick1Hz), .BuzzerBit(BuzzerBit),
    .Mode(Mode),
    .Button1Tk(Button1Tk), .Button2Tk(Button2Tk),
    .Button1Alm(Button1Alm), .Button2Alm(Button2Alm), .Button3Alm(Button3Alm),
    .Button1Sw(Button1Sw), .Button2Sw(Button2Sw)
  );

  initial forever #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int sCnt[7];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a button's level flips once its last DEB synchronized samples all
  // disagree with it; mode/strobes follow the priority and timeout rules.
  bit mS1[3], mS2[3], mLvl[3], mPress[3], raw[3];
  bit mHist[3][DEB];
  int mFill[3];
  int mMode = 0, mIdle = 0, oldMode;
  bit [6:0] eStrobe = '0;
  bit allDiff, acc;
  int route1[3];
  int route2[3];

  initial begin
    route1 = '{S_TK1, S_ALM1, S_SW1};
    route2 = '{S_TK2, S_ALM2, S_SW2};
  end

  initial forever begin
    @(posedge Clk or posedge Rst);
    if (Rst) begin
      for (int b = 0; b < 3; b++) begin
        mS1[b] = 0; mS2[b] = 0; mLvl[b] = 0; mPress[b] = 0; mFill[b] = 0;
        for (int k = 0; k < DEB; k++) mHist[b][k] = 0;
      end
      mMode = 0; mIdle = 0; eStrobe = '0;
    end else begin
      raw[0] = Button1; raw[1] = Button2; raw[2] = Button3;
      eStrobe = '0;
      oldMode = mMode;
      acc = mPress[0] | mPress[1] | mPress[2];
      if (mPress[2]) begin
        if (BuzzerBit) eStrobe[S_ALM3] = 1'b1;
        else mMode = (oldMode + 1) % 3;
      end else if (mPress[0]) begin
        eStrobe[route1[oldMode]] = 1'b1;
      end else if (mPress[1]) begin
        eStrobe[route2[oldMode]] = 1'b1;
      end
      if (oldMode == 1) begin
        if (acc) mIdle = 0;
        else if (mIdle == TO) begin mMode = 0; mIdle = 0; end
        else if (Tick1Hz) mIdle = mIdle + 1;
      end else begin
        mIdle = 0;
      end
      for (int b = 0; b < 3; b++) begin
        for (int k = 0; k < DEB - 1; k++) mHist[b][k] = mHist[b][k+1];
        mHist[b][DEB-1] = mS2[b];
        if (mFill[b] < DEB) mFill[b]++;
        allDiff = (mFill[b] == DEB);
        for (int k = 0; k < DEB; k++) if (mHist[b][k] == mLvl[b]) allDiff = 0;
        mPress[b] = allDiff && !mLvl[b];
        if (allDiff) mLvl[b] = !mLvl[b];
        mS2[b] = mS1[b];
        mS1[b] = raw[b];
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    checkOutput("modelMode", int'(Mode), mMode);
    checkOutput("modelStrobes", int'(dutStrobe), int'(eStrobe));
    for (int k = 0; k < 7; k++) if (dutStrobe[k]) sCnt[k]++;
  end

  function automatic int sumCnt();
    int s = 0;
    for (int k = 0; k < 7; k++) s += sCnt[k];
    return s;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input int b, input bit v);
    case (b)
      1: Button1 = v;
      2: Button2 = v;
      default: Button3 = v;
    endcase
  endtask

  task automatic pressButton(input int b);
    applyStimulus(b, 1'b1);
    waitCycles(9);
    applyStimulus(b, 1'b0);
    waitCycles(9);
  endtask

  task automatic tickPulse();
    Tick1Hz = 1'b1;
    waitCycles(1);
    Tick1Hz = 1'b0;
    waitCycles(1);
  endtask

  int base, base2, firstAt, hold[3];

  initial begin
    waitCycles(3);
    checkOutput("resetMode", int'(Mode), 0);
    checkOutput("resetStrobes", int'(dutStrobe), 0);
    Rst = 1'b0;
    waitCycles(10);

    // Button1 held: one strobe, 7 cycles after the drive.
    base = sCnt[S_TK1]; firstAt = -1;
    Button1 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge Clk);
      if (Button1Tk && firstAt < 0) firstAt = i;
    end
    #1;
    checkOutput("holdLatency", firstAt, 7);
    checkOutput("holdCount", sCnt[S_TK1] - base, 1);
    Button1 = 1'b0;
    waitCycles(10);

    // Bounce on Button2, then stable.
    base = sCnt[S_TK2];
    for (int i = 0; i < 10; i++) begin
      Button2 = ~Button2;
      waitCycles(2);
    end
    checkOutput("bounceCount", sCnt[S_TK2] - base, 0);
    Button2 = 1'b1;
    waitCycles(12);
    checkOutput("stableCount", sCnt[S_TK2] - base, 1);
    Button2 = 1'b0;
    waitCycles(10);

    // Mode cycling and STOPWATCH routing.
    pressButton(3);
    checkOutput("modeAlarm", int'(Mode), 1);
    pressButton(3);
    checkOutput("modeSw", int'(Mode), 2);
    base = sCnt[S_SW1]; base2 = sumCnt();
    pressButton(1);
    checkOutput("swB1", sCnt[S_SW1] - base, 1);
    checkOutput("swOnly", sumCnt() - base2, 1);
    pressButton(3);
    checkOutput("modeTime", int'(Mode), 0);

    // Buzzer active: Button3 goes to alarm block, no mode change.
    pressButton(3);
    BuzzerBit = 1'b1;
    base = sCnt[S_ALM3];
    pressButton(3);
    checkOutput("buzzAlm3", sCnt[S_ALM3] - base, 1);
    checkOutput("buzzMode", int'(Mode), 1);
    BuzzerBit = 1'b0;

    // Idle timeout.
    tickPulse(); tickPulse();
    checkOutput("idle2Mode", int'(Mode), 1);
    tickPulse();
    checkOutput("timeoutMode", int'(Mode), 0);

    // Press on the timeout tick wins and clears the counter.
    pressButton(3);
    tickPulse(); tickPulse();
    base = sCnt[S_ALM1];
    Button1 = 1'b1;
    waitCycles(6);
    Tick1Hz = 1'b1;
    waitCycles(1);
    Tick1Hz = 1'b0;
    waitCycles(3);
    checkOutput("raceAlm1", sCnt[S_ALM1] - base, 1);
    checkOutput("raceMode", int'(Mode), 1);
    Button1 = 1'b0;
    waitCycles(8);
    tickPulse(); tickPulse();
    checkOutput("clearedMode", int'(Mode), 1);
    tickPulse();
    checkOutput("clearedTimeout", int'(Mode), 0);

    // Simultaneous Button1+Button3.
    base = sumCnt();
    Button1 = 1'b1; Button3 = 1'b1;
    waitCycles(10);
    checkOutput("simulMode", int'(Mode), 1);
    checkOutput("simulNoStrobe", sumCnt() - base, 0);
    Button1 = 1'b0; Button3 = 1'b0;
    waitCycles(8);

    // Reset mid-debounce from ALARM.
    base = sumCnt();
    Button1 = 1'b1;
    waitCycles(3);
    Rst = 1'b1;
    #1;
    checkOutput("rstImmediateMode", int'(Mode), 0);
    Button1 = 1'b0;
    waitCycles(3);
    Rst = 1'b0;
    waitCycles(12);
    checkOutput("rstDiscard", sumCnt() - base, 0);

    // Held through reset release: one press after sync + debounce.
    Button1 = 1'b1;
    waitCycles(1);
    Rst = 1'b1;
    waitCycles(2);
    base = sCnt[S_TK1]; firstAt = -1;
    Rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge Clk);
      if (Button1Tk && firstAt < 0) firstAt = i;
    end
    #1;
    checkOutput("rstHeldLatency", firstAt, 7);
    checkOutput("rstHeldCount", sCnt[S_TK1] - base, 1);
    Button1 = 1'b0;
    waitCycles(10);

    // Random phase.
    for (int b = 0; b < 3; b++) hold[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          applyStimulus(b + 1, 1'($urandom_range(0, 1)));
          hold[b] = $urandom_range(1, 12);
        end else begin
          hold[b]--;
        end
      end
      Tick1Hz = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 63) == 0) BuzzerBit = ~BuzzerBit;
      if ($urandom_range(0, 999) == 0) Rst = 1'b1;
      waitCycles(1);
      Rst = 1'b0;
    end
    Tick1Hz = 1'b0;
    waitCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
